// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: measures hsync/vsync periods, locks after repeated matching
// frames, and emits active-area pixel coordinates with colour.
//
//   state   | meaning
//   SEARCH  | waiting for a frame start
//   MEASURE | capturing line and frame periods for one frame
//   VERIFY  | counting consecutive frames that repeat the captured periods
//   LOCKED  | periods stable; active-area pixels are reported
module vga_sync_receiver #(
  parameter int H_BACK      = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_BACK      = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  output logic       locked,
  output logic       err,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       px_valid,
  output logic       sof,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] px_r,
  output logic [7:0] px_g,
  output logic [7:0] px_b
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [9:0]  CNT_MAX   = 10'd1023;
  localparam logic [9:0]  H_START   = 10'(H_BACK);
  localparam logic [9:0]  H_END     = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_START   = 10'(V_BACK);
  localparam logic [9:0]  V_END     = 10'(V_BACK + V_ACTIVE);
  localparam logic [10:0] H_MIN     = 11'(H_BACK + H_ACTIVE);
  localparam logic [10:0] V_MIN     = 11'(V_BACK + V_ACTIVE);
  localparam logic [3:0]  MATCH_TGT = 4'(LOCK_FRAMES);

  state_t      state, state_nxt;
  logic        hs_q, hs_q_d, vs_q, vs_q_d;
  logic [23:0] rgb_q, rgb_qq;
  logic        ls, fs;
  logic [9:0]  h_cnt, v_cnt;
  logic [10:0] line_per, frame_per;
  logic [10:0] h_ref, h_ref_nxt, v_ref, v_ref_nxt;
  logic [3:0]  match_cnt, match_nxt, match_inc;
  logic        fail, line_bad, frame_bad, h_sat;
  logic        h_act, v_act, lock_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= 1'b0;
      hs_q_d <= 1'b0;
      vs_q   <= 1'b0;
      vs_q_d <= 1'b0;
      rgb_q  <= '0;
      rgb_qq <= '0;
    end else begin
      hs_q   <= hsync;
      hs_q_d <= hs_q;
      vs_q   <= vsync;
      vs_q_d <= vs_q;
      rgb_q  <= {R, G, B};
      rgb_qq <= rgb_q;
    end
  end

  assign ls = hs_q & ~hs_q_d;
  assign fs = vs_q & ~vs_q_d;

  // Counters saturate so a missing sync stays detectable instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (ls)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 10'd1;
      if (fs)
        v_cnt <= '0;
      else if (ls && (v_cnt != CNT_MAX))
        v_cnt <= v_cnt + 10'd1;
    end
  end

  assign line_per  = {1'b0, h_cnt} + 11'd1;
  assign frame_per = {1'b0, v_cnt} + 11'd1;
  assign line_bad  = ls && (line_per != h_ref);
  assign frame_bad = fs && (frame_per != v_ref);
  assign h_sat     = (h_cnt == CNT_MAX);
  assign match_inc = match_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    h_ref_nxt = h_ref;
    v_ref_nxt = v_ref;
    match_nxt = match_cnt;
    fail      = 1'b0;
    case (state)
      SEARCH: begin
        if (fs) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (ls) h_ref_nxt = line_per;
        if (h_sat) begin
          fail = 1'b1;
        end else if (fs) begin
          v_ref_nxt = frame_per;
          if ((h_ref_nxt >= H_MIN) && (v_ref_nxt >= V_MIN)) begin
            state_nxt = VERIFY;
            match_nxt = '0;
          end else begin
            state_nxt = SEARCH;
          end
        end
      end
      VERIFY: begin
        if (h_sat || line_bad || frame_bad) begin
          fail = 1'b1;
        end else if (fs) begin
          match_nxt = match_inc;
          if (match_inc == MATCH_TGT) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (h_sat || line_bad || frame_bad) fail = 1'b1;
      end
      default: state_nxt = SEARCH;
    endcase
    if (fail) begin
      state_nxt = SEARCH;
      match_nxt = '0;
    end
  end

  assign locked   = (state == LOCKED);
  assign lock_nxt = (state_nxt == LOCKED);
  assign h_act    = (h_cnt >= H_START) && (h_cnt < H_END);
  assign v_act    = (v_cnt >= V_START) && (v_cnt < V_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      h_ref     <= '0;
      v_ref     <= '0;
      match_cnt <= '0;
      err       <= 1'b0;
      h_total   <= '0;
      v_total   <= '0;
      px_valid  <= 1'b0;
      sof       <= 1'b0;
      x         <= '0;
      y         <= '0;
      px_r      <= '0;
      px_g      <= '0;
      px_b      <= '0;
    end else begin
      state     <= state_nxt;
      h_ref     <= h_ref_nxt;
      v_ref     <= v_ref_nxt;
      match_cnt <= match_nxt;
      err       <= fail && (state == LOCKED);
      h_total   <= lock_nxt ? h_ref_nxt[9:0] : 10'd0;
      v_total   <= lock_nxt ? v_ref_nxt[9:0] : 10'd0;
      // Decode against the next state so px_valid never outlives a lock loss.
      px_valid  <= lock_nxt && h_act && v_act;
      sof       <= lock_nxt && (h_cnt == H_START) && (v_cnt == V_START);
      x         <= h_cnt - H_START;
      y         <= v_cnt - V_START;
      {px_r, px_g, px_b} <= rgb_qq;
    end
  end

endmodule
